sigmoid_sweep_harness: RTL and testbench
========================================

# sigmoid_sweep_harness

Synthesizable on-chip stimulus driver and result collector for `sigmoid_pipelined`. It generates an arithmetic sweep of bf16 bit patterns and presents them one at a time on the approximator's valid/data input. It waits for each result, captures it into an internal RAM, and lets a host read the captured results back. It is the hardware counterpart of the file-driven simulation flow and is used for on-board characterisation of the approximator.

## Interface
Parameters:
- DEPTH, 256: capture RAM entries; must be a power of 2.
- ADDR_W, 8: log2(DEPTH).
- TIMEOUT, 64: maximum cycles to wait in any handshake phase.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only when busy=0.
- base  in  16  first bf16 bit pattern; sampled on the start cycle.
- step  in  16  bit-pattern increment per sample; sampled on the start cycle.
- count  in  ADDR_W+1  number of samples; sampled on the start cycle.
- dut_valid_in  out  1  drives the sigmoid `valid_in`.
- dut_data_in  out  16  drives the sigmoid `data_in`.
- dut_valid_out  in  1  from the sigmoid `valid_out`.
- dut_data_out  in  16  from the sigmoid `data_out`.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  16  registered read data: mem[rd_addr] one cycle later.
- busy  out  1  high while a sweep is in progress.
- done  out  1  sticky; set when a sweep ends and cleared by the next accepted start.
- timeout_err  out  1  sticky; set on a handshake timeout and cleared by the next accepted start.
- n_captured  out  ADDR_W+1  number of results written in the current or last sweep.

## Operation
- FSM states: IDLE, WAIT_HI, WAIT_LO.
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including dut_valid_in, dut_data_in, rd_data, busy, done, timeout_err and n_captured.
  - RAM contents are undefined.
- IDLE, start=1 with count=0: done←1, timeout_err←0, n_captured←0. State stays IDLE. dut_valid_in is never raised.
- IDLE, start=1 with count≠0:
  - Latch step.
  - Latch len = min(count, DEPTH).
  - Set idx←0, dut_data_in←base, dut_valid_in←1, busy←1, done←0, timeout_err←0, n_captured←0.
  - Go to WAIT_HI.
- WAIT_HI, dut_valid_out=1:
  - Write mem[idx]←dut_data_out.
  - Increment n_captured.
  - Set dut_valid_in←0.
  - Go to WAIT_LO.
- WAIT_LO, dut_valid_out=0:
  - Increment idx.
  - If idx+1=len: busy←0, done←1, go to IDLE.
  - Otherwise: dut_data_in←dut_data_in+step (mod 2^16), dut_valid_in←1, go to WAIT_HI.
- Timeout:
  - A cycle counter resets on every state entry and counts cycles spent in WAIT_HI or WAIT_LO.
  - When it reaches TIMEOUT: timeout_err←1, done←1, busy←0, dut_valid_in←0, go to IDLE.
  - Nothing is written on a timeout.
- start while busy=1 is ignored, with no side effects.
- dut_data_in is held stable for the whole time dut_valid_in=1.
- Host reads are allowed at any time. A read of the address being written on the same edge returns the old data.
- Arithmetic: the increment wraps modulo 2^16 with no bf16 interpretation. count values above DEPTH are clamped to DEPTH.

## Timing
- Start accepted at edge 0 → dut_valid_in=1 and dut_data_in=base visible after edge 0.
- dut_valid_out first sampled high at edge k → capture at edge k, and dut_valid_in is low after edge k.
- dut_valid_out sampled low at edge m → the next sample's dut_valid_in is high after edge m.
- A single-cycle dut_valid_out pulse is captured exactly once.
- Per-sample cost is pipeline latency + 2 cycles minimum. The pipeline is never overlapped.
- done and busy change on the same edge as the final WAIT_LO exit or the timeout.
- rd_data has 1-cycle read latency.
- Asynchronous rst mid-sweep immediately forces all outputs to their reset values. A new start after reset release runs normally.

## Test plan
Use a behavioural responder that, L cycles after seeing valid_in=1, asserts valid_out for 1 cycle with data = data_in ^ 16'h8000.

- **Basic sweep:** base=16'h3F80, step=1, count=4, L=3 → mem[0..3]=16'hBF80..16'hBF83, n_captured=4, done=1, timeout_err=0, busy low after the 4th WAIT_LO exit.
- **Zero count:** count=0 → done=1 one cycle after start, dut_valid_in stays 0 throughout, n_captured=0.
- **Timeout:** responder disabled, TIMEOUT=64 → timeout_err=1 and done=1 exactly 64 cycles after dut_valid_in rises, dut_valid_in=0, n_captured=0.
- **Wrap-around:** base=16'hFFFE, step=1, count=3 → dut_data_in sequence 16'hFFFE, 16'hFFFF, 16'h0000; mem[2]=16'h8000.
- **Clamp and ignored start:** count=300 → n_captured=256. A start pulsed mid-sweep with base=16'h1234 does not alter dut_data_in or idx.
- **Reset mid-operation:** assert rst during WAIT_HI of sample 2 → all outputs 0 immediately. After release, a start with base=16'h4000, count=1 yields mem[0]=16'hC000 and done=1.

Source files
------------

// File: rtl/sigmoid_sweep_harness_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sigmoid_sweep_harness_if - host control, approximator handshake and readback
// Revision: 1.0
// -----------------------------------------------------------------------------
interface sigmoid_sweep_harness_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic [15:0]       base;
  logic [15:0]       step;
  logic [ADDR_W:0]   count;
  logic              dut_valid_in;
  logic [15:0]       dut_data_in;
  logic              dut_valid_out;
  logic [15:0]       dut_data_out;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic [ADDR_W:0]   n_captured;

  // master is the harness; slave is the host plus the approximator it drives
  modport master (
    input  start, base, step, count, dut_valid_out, dut_data_out, rd_addr,
    output dut_valid_in, dut_data_in, rd_data, busy, done, timeout_err, n_captured
  );

  modport slave (
    output start, base, step, count, dut_valid_out, dut_data_out, rd_addr,
    input  dut_valid_in, dut_data_in, rd_data, busy, done, timeout_err, n_captured
  );
endinterface
`default_nettype wire

// File: rtl/sigmoid_sweep_harness.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sigmoid_sweep_harness - bf16 sweep stimulus driver with result capture RAM
// Revision: 1.0
// -----------------------------------------------------------------------------
module sigmoid_sweep_harness #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input wire clk,
  input wire rst,
  sigmoid_sweep_harness_if.master bus
);
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   c_tmax    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   c_t_one   = TW'(1);
  localparam logic [ADDR_W:0] c_depth   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] c_idx_one = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } state_t;

  state_t          r_state;
  logic [15:0]     r_step;
  logic [ADDR_W:0] r_len;
  logic [ADDR_W:0] r_idx;
  logic [TW-1:0]   r_timer;
  logic [15:0]     r_mem [DEPTH];

  logic            w_wr;
  logic [ADDR_W:0] w_idx_nxt;

  assign w_wr      = (r_state == WAIT_HI) && bus.dut_valid_out;
  assign w_idx_nxt = r_idx + c_idx_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_step           <= '0;
      r_len            <= '0;
      r_idx            <= '0;
      r_timer          <= '0;
      bus.dut_valid_in <= 1'b0;
      bus.dut_data_in  <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.n_captured   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            bus.done        <= (bus.count == '0);
            bus.timeout_err <= 1'b0;
            bus.n_captured  <= '0;
            if (bus.count != '0) begin
              r_step           <= bus.step;
              r_len            <= (bus.count > c_depth) ? c_depth : bus.count;
              r_idx            <= '0;
              r_timer          <= '0;
              bus.dut_data_in  <= bus.base;
              bus.dut_valid_in <= 1'b1;
              bus.busy         <= 1'b1;
              r_state          <= WAIT_HI;
            end
          end
        end

        WAIT_HI: begin
          // A response landing on the expiry cycle still counts as captured
          if (bus.dut_valid_out) begin
            bus.n_captured   <= bus.n_captured + c_idx_one;
            bus.dut_valid_in <= 1'b0;
            r_timer          <= '0;
            r_state          <= WAIT_LO;
          end else if (r_timer == c_tmax) begin
            bus.timeout_err  <= 1'b1;
            bus.done         <= 1'b1;
            bus.busy         <= 1'b0;
            bus.dut_valid_in <= 1'b0;
            r_state          <= IDLE;
          end else begin
            r_timer <= r_timer + c_t_one;
          end
        end

        WAIT_LO: begin
          if (!bus.dut_valid_out) begin
            r_idx   <= w_idx_nxt;
            r_timer <= '0;
            if (w_idx_nxt == r_len) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              r_state  <= IDLE;
            end else begin
              bus.dut_data_in  <= bus.dut_data_in + r_step;
              bus.dut_valid_in <= 1'b1;
              r_state          <= WAIT_HI;
            end
          end else if (r_timer == c_tmax) begin
            bus.timeout_err  <= 1'b1;
            bus.done         <= 1'b1;
            bus.busy         <= 1'b0;
            bus.dut_valid_in <= 1'b0;
            r_state          <= IDLE;
          end else begin
            r_timer <= r_timer + c_t_one;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Capture RAM has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_idx[ADDR_W-1:0]] <= bus.dut_data_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else begin
      bus.rd_data <= r_mem[bus.rd_addr];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sigmoid_sweep_harness.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sigmoid_sweep_harness - randomized and directed sweeps with a scoreboard
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_sigmoid_sweep_harness;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sigmoid_sweep_harness_if #(.ADDR_W(ADDR_W)) bus ();

  sigmoid_sweep_harness #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural pipeline stand-in: one pulse per valid_in assertion, L cycles later
  int          resp_lat;
  bit          resp_en;
  bit          resp_busy;
  bit          resp_seen;
  int          resp_cnt;
  logic [15:0] resp_data;

  always @(negedge clk) begin
    if (rst || !resp_en) begin
      resp_busy         = 1'b0;
      resp_seen         = 1'b0;
      bus.dut_valid_out = 1'b0;
    end else begin
      bus.dut_valid_out = 1'b0;
      if (!bus.dut_valid_in) resp_seen = 1'b0;
      if (resp_busy) begin
        if (resp_cnt == 0) begin
          bus.dut_valid_out = 1'b1;
          bus.dut_data_out  = resp_data ^ 16'h8000;
          resp_busy         = 1'b0;
        end else begin
          resp_cnt = resp_cnt - 1;
        end
      end else if (!resp_seen && bus.dut_valid_in) begin
        resp_busy = 1'b1;
        resp_seen = 1'b1;
        resp_data = bus.dut_data_in;
        resp_cnt  = resp_lat - 1;
      end
    end
  end

  // Scoreboard monitor: each new valid_in must present the next expected pattern
  logic [15:0] exp_q[$];
  logic        prev_vin;
  logic [15:0] prev_din;

  always @(negedge clk) begin
    if (rst) begin
      prev_vin = 1'b0;
    end else begin
      if (bus.dut_valid_in && !prev_vin) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid_in: data_in=%h with no sample pending", bus.dut_data_in);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (bus.dut_data_in !== e) begin
            bad++;
            $display("FAIL data_in_seq: got %h expected %h", bus.dut_data_in, e);
          end
        end
      end else if (bus.dut_valid_in && prev_vin) begin
        total++;
        if (bus.dut_data_in !== prev_din) begin
          bad++;
          $display("FAIL data_in_stable: got %h expected %h", bus.dut_data_in, prev_din);
        end
      end
      prev_vin = bus.dut_valid_in;
      prev_din = bus.dut_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that samples start
  task automatic do_start(input logic [15:0] b, input logic [15:0] s, input logic [ADDR_W:0] c);
    bus.start = 1'b1;
    bus.base  = b;
    bus.step  = s;
    bus.count = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] b, input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'(b + i * s));
  endtask

  task automatic wait_done(input int max_cyc);
    int k;
    k = 0;
    while (!(bus.done && !bus.busy) && k < max_cyc) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("sweep_completes", {31'd0, (k < max_cyc)}, 32'd1);
  endtask

  task automatic check_mem(input logic [15:0] b, input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rd_addr = ADDR_W'(i);
      @(posedge clk);
      #1;
      chk($sformatf("mem[%0d]", i), {16'd0, bus.rd_data}, {16'd0, 16'(b + i * s) ^ 16'h8000});
    end
  endtask

  task automatic sweep(input logic [15:0] b, input logic [15:0] s, input int c, input int lat);
    int n;
    n = (c > DEPTH) ? DEPTH : c;
    resp_lat = lat;
    push_exp(b, s, n);
    do_start(b, s, (ADDR_W + 1)'(c));
    wait_done(n * (lat + 4) + 20);
    chk("n_captured", 32'(bus.n_captured), 32'(n));
    chk("done", {31'd0, bus.done}, 32'd1);
    chk("timeout_err", {31'd0, bus.timeout_err}, 32'd0);
    check_mem(b, s, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    resp_en = 1'b1;
    resp_lat = 3;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base = '0;
    bus.step = '0;
    bus.count = '0;
    bus.rd_addr = '0;
    bus.dut_valid_out = 1'b0;
    bus.dut_data_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.dut_valid_in, bus.dut_data_in, bus.busy, bus.done, bus.timeout_err, 5'd0},
        32'd0);
    chk("reset_rd_ncap", {7'd0, bus.rd_data, bus.n_captured}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic sweep
    sweep(16'h3F80, 16'd1, 4, 3);
    chk("busy_after_basic", {31'd0, bus.busy}, 32'd0);

    // Randomized sweeps against the arithmetic model
    for (int t = 0; t < 6; t++) begin
      sweep(16'($urandom), 16'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(1, 6)));
    end

    // Timeout with the responder silenced
    resp_en = 1'b0;
    push_exp(16'h1357, 16'd1, 1);
    do_start(16'h1357, 16'd1, 9'd3);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("timeout_not_early", {30'd0, bus.timeout_err, bus.busy}, 32'd1);
    @(posedge clk);
    #1;
    chk("timeout_err_set", {31'd0, bus.timeout_err}, 32'd1);
    chk("timeout_done", {30'd0, bus.done, bus.busy}, 32'd2);
    chk("timeout_valid_in", {31'd0, bus.dut_valid_in}, 32'd0);
    chk("timeout_ncap", 32'(bus.n_captured), 32'd0);
    resp_en = 1'b1;

    // Zero count right after a timeout so the flag clears observably
    do_start(16'hAAAA, 16'd1, 9'd0);
    chk("zero_done", {30'd0, bus.done, bus.busy}, 32'd2);
    chk("zero_terr_ncap", {22'd0, bus.timeout_err, bus.n_captured}, 32'd0);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("zero_valid_in", {31'd0, bus.dut_valid_in}, 32'd0);
    end

    // Wrap-around of the bit-pattern increment
    sweep(16'hFFFE, 16'd1, 3, 2);

    // Clamp to DEPTH, with an ignored start in the middle of the sweep
    resp_lat = 1;
    push_exp(16'h0100, 16'd3, DEPTH);
    do_start(16'h0100, 16'd3, 9'd300);
    repeat (40) @(posedge clk);
    #1;
    chk("busy_mid_clamp", {31'd0, bus.busy}, 32'd1);
    do_start(16'h1234, 16'd7, 9'd5);
    wait_done(DEPTH * 6 + 20);
    chk("clamp_ncap", 32'(bus.n_captured), 32'(DEPTH));
    chk("clamp_done", {30'd0, bus.done, bus.timeout_err}, 32'd2);
    check_mem(16'h0100, 16'd3, DEPTH);

    // Asynchronous reset while waiting on the third sample
    resp_lat = 4;
    push_exp(16'h1111, 16'd3, 5);
    do_start(16'h1111, 16'd3, 9'd5);
    bus.rd_addr = '0;
    begin
      int k;
      k = 0;
      while (!(bus.n_captured == 9'd2 && bus.dut_valid_in) && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("reach_sample2", {31'd0, (k < 100)}, 32'd1);
    end
    chk("rd_data_before_rst", {16'd0, bus.rd_data}, {16'd0, 16'h1111 ^ 16'h8000});
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {bus.dut_valid_in, bus.dut_data_in, bus.busy, bus.done, bus.timeout_err, 5'd0},
        32'd0);
    chk("rst_mid_rd_ncap", {7'd0, bus.rd_data, bus.n_captured}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sweep(16'h4000, 16'd0, 1, 2);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
